// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/decode/execute loop with shared-bus arbitration.
// Traps illegal opcodes and units that never report done.
module exec_sequencer #(
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 fetch_start,
    input  logic                 fetch_done,
    input  logic [15:0]          instr,
    output logic [5:0]           param1,
    output logic [5:0]           param2,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS:0]   bus_grant,
    output logic                 halted,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [15:0]          instr_count
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_HALT,
        S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          ir_q, ir_d;
    logic                 fstart_q, fstart_d;
    logic [NUM_UNITS-1:0] ustart_q, ustart_d;
    logic [NUM_UNITS:0]   grant_q, grant_d;
    logic                 halted_q, halted_d;
    logic                 error_q, error_d;
    logic [1:0]           ecode_q, ecode_d;
    logic [15:0]          count_q, count_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    logic [NUM_UNITS-1:0] sel;
    logic                 op_ok;
    logic                 done_sel;
    logic                 tmo_hit;

    // One-hot unit select from the latched opcode; empty for illegal ops.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            sel[i] = (ir_q[15:12] == 4'(i));
        end
    end

    assign op_ok    = |sel;
    assign done_sel = |(unit_done & sel);
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ecode_d = ecode_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_done) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    ecode_d = 2'd1;
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (op_ok) begin
                    state_d = S_EXEC;
                end else if (ir_q[15:12] == 4'hF) begin
                    state_d = S_HALT;
                end else begin
                    ecode_d = 2'd3;
                    state_d = S_ERR;
                end
            end
            S_EXEC: state_d = S_WAIT;
            S_WAIT: begin
                if (done_sel) begin
                    count_d = count_q + 16'd1;
                    state_d = run ? S_FETCH : S_IDLE;
                end else if (tmo_hit) begin
                    ecode_d = 2'd2;
                    state_d = S_ERR;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        fstart_d = (state_d == S_FETCH) && (state_q != S_FETCH);
        ustart_d = (state_d == S_EXEC) ? sel : '0;
        grant_d  = '0;
        if (state_d == S_FETCH) begin
            grant_d[0] = 1'b1;
        end else if (state_d == S_EXEC || state_d == S_WAIT) begin
            grant_d = {sel, 1'b0};
        end
        halted_d = halted_q | (state_d == S_HALT);
        error_d  = error_q | (state_d == S_ERR);
        tmo_d    = '0;
        if (state_d == state_q) tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            fstart_q <= 1'b0;
            ustart_q <= '0;
            grant_q  <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            ecode_q  <= '0;
            count_q  <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            fstart_q <= fstart_d;
            ustart_q <= ustart_d;
            grant_q  <= grant_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            ecode_q  <= ecode_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
        end
    end

    assign fetch_start = fstart_q;
    assign param1      = ir_q[11:6];
    assign param2      = ir_q[5:0];
    assign unit_start  = ustart_q;
    assign bus_grant   = grant_q;
    assign halted      = halted_q;
    assign error       = error_q;
    assign err_code    = ecode_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: one task per scenario, inline checks.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_exec_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        fetch_start;
    logic        fetch_done;
    logic [15:0] instr;
    logic [5:0]  param1;
    logic [5:0]  param2;
    logic [3:0]  unit_start;
    logic [3:0]  unit_done;
    logic [4:0]  bus_grant;
    logic        halted;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] instr_count;

    int total = 0;
    int bad   = 0;

    exec_sequencer #(.NUM_UNITS(4), .TIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .fetch_start(fetch_start),
        .fetch_done(fetch_done),
        .instr(instr),
        .param1(param1),
        .param2(param2),
        .unit_start(unit_start),
        .unit_done(unit_done),
        .bus_grant(bus_grant),
        .halted(halted),
        .error(error),
        .err_code(err_code),
        .instr_count(instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        run        = 1'b0;
        fetch_done = 1'b0;
        unit_done  = 4'b0;
        instr      = 16'h0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({fetch_start, unit_start, bus_grant} !== 10'b0) begin
            bad++;
            $display("FAIL rst_ctl got=%b exp=0",
                     {fetch_start, unit_start, bus_grant});
        end
        total++;
        if ({halted, error, err_code, param1, param2} !== 16'h0) begin
            bad++;
            $display("FAIL rst_stat got=%h exp=0",
                     {halted, error, err_code, param1, param2});
        end
        total++;
        if (instr_count !== 16'h0) begin
            bad++;
            $display("FAIL rst_cnt got=%h exp=0", instr_count);
        end
        cyc(3);
        total++;
        if ({fetch_start, bus_grant} !== 6'b0) begin
            bad++;
            $display("FAIL idle_hold got=%b exp=0", {fetch_start, bus_grant});
        end
    endtask

    task automatic test_movi();
        do_reset();
        run   = 1'b1;
        instr = 16'h0085;
        cyc(1);
        total++;
        if ({fetch_start, bus_grant} !== 6'b1_00001) begin
            bad++;
            $display("FAIL movi_fetch got=%b exp=100001",
                     {fetch_start, bus_grant});
        end
        cyc(1);
        total++;
        if ({fetch_start, bus_grant} !== 6'b0_00001) begin
            bad++;
            $display("FAIL movi_fetch2 got=%b exp=000001",
                     {fetch_start, bus_grant});
        end
        cyc(2);
        fetch_done = 1'b1;
        cyc(1);
        fetch_done = 1'b0;
        total++;
        if ({param1, param2} !== {6'd2, 6'd5} || bus_grant !== 5'b0) begin
            bad++;
            $display("FAIL movi_decode got=%0d/%0d/%b exp=2/5/00000",
                     param1, param2, bus_grant);
        end
        cyc(1);
        total++;
        if ({unit_start, bus_grant} !== 9'b0001_00010) begin
            bad++;
            $display("FAIL movi_exec got=%b exp=000100010",
                     {unit_start, bus_grant});
        end
        cyc(1);
        total++;
        if ({unit_start, bus_grant} !== 9'b0000_00010) begin
            bad++;
            $display("FAIL movi_wait got=%b exp=000000010",
                     {unit_start, bus_grant});
        end
        cyc(1);
        unit_done = 4'b0001;
        run       = 1'b0;
        cyc(1);
        unit_done = 4'b0;
        total++;
        if (instr_count !== 16'd1 || bus_grant !== 5'b0) begin
            bad++;
            $display("FAIL movi_retire got=%0d/%b exp=1/00000",
                     instr_count, bus_grant);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] gexp [3];
        logic [3:0] sexp [3];
        gexp = '{5'b00100, 5'b01000, 5'b10000};
        sexp = '{4'b0010, 4'b0100, 4'b1000};
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = {4'(k + 1), 12'h0};
            cyc(1);
            unit_done = 4'b0;
            total++;
            if ({fetch_start, bus_grant} !== 6'b1_00001) begin
                bad++;
                $display("FAIL b2b_fetch%0d got=%b exp=100001",
                         k + 1, {fetch_start, bus_grant});
            end
            fetch_done = 1'b1;
            cyc(1);
            fetch_done = 1'b0;
            cyc(1);
            total++;
            if (bus_grant !== gexp[k] || unit_start !== sexp[k]) begin
                bad++;
                $display("FAIL b2b_exec%0d got=%b/%b exp=%b/%b",
                         k + 1, bus_grant, unit_start, gexp[k], sexp[k]);
            end
            cyc(1);
            total++;
            if ($countones(bus_grant) > 1 || bus_grant !== gexp[k]) begin
                bad++;
                $display("FAIL b2b_wait%0d got=%b exp=%b",
                         k + 1, bus_grant, gexp[k]);
            end
            unit_done = sexp[k];
            if (k == 2) run = 1'b0;
        end
        cyc(1);
        unit_done = 4'b0;
        total++;
        if (instr_count !== 16'd3 || fetch_start !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got=%0d/%b exp=3/0",
                     instr_count, fetch_start);
        end
    endtask

    task automatic test_halt();
        int nfs;
        int nlow;
        nfs  = 0;
        nlow = 0;
        do_reset();
        run   = 1'b1;
        instr = 16'hF000;
        cyc(1);
        fetch_done = 1'b1;
        cyc(1);
        fetch_done = 1'b0;
        cyc(1);
        total++;
        if (halted !== 1'b1 || bus_grant !== 5'b0) begin
            bad++;
            $display("FAIL halt_enter got=%b/%b exp=1/00000",
                     halted, bus_grant);
        end
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            cyc(1);
            if (fetch_start || bus_grant != 5'b0) nfs++;
            if (!halted) nlow++;
        end
        total++;
        if (nfs !== 0 || nlow !== 0) begin
            bad++;
            $display("FAIL halt_sticky got=%0d/%0d exp=0/0", nfs, nlow);
        end
        total++;
        if (instr_count !== 16'd0) begin
            bad++;
            $display("FAIL halt_count got=%0d exp=0", instr_count);
        end
    endtask

    task automatic test_illegal();
        int nus;
        nus = 0;
        do_reset();
        run   = 1'b1;
        instr = 16'h7000;
        cyc(1);
        fetch_done = 1'b1;
        cyc(1);
        fetch_done = 1'b0;
        if (unit_start != 4'b0) nus++;
        cyc(1);
        total++;
        if ({error, err_code, bus_grant} !== 8'b1_11_00000) begin
            bad++;
            $display("FAIL illegal_err got=%b exp=11100000",
                     {error, err_code, bus_grant});
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (unit_start != 4'b0) nus++;
        end
        total++;
        if (nus !== 0 || error !== 1'b1) begin
            bad++;
            $display("FAIL illegal_hold got=%0d/%b exp=0/1", nus, error);
        end
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        run = 1'b1;
        cyc(1);
        cyc(63);
        total++;
        if (error !== 1'b0 || bus_grant !== 5'b00001) begin
            bad++;
            $display("FAIL ftmo_early got=%b/%b exp=0/00001",
                     error, bus_grant);
        end
        cyc(1);
        total++;
        if ({error, err_code, bus_grant} !== 8'b1_01_00000) begin
            bad++;
            $display("FAIL ftmo_err got=%b exp=10100000",
                     {error, err_code, bus_grant});
        end
    endtask

    task automatic test_exec_timeout();
        do_reset();
        run   = 1'b1;
        instr = 16'h1000;
        cyc(1);
        fetch_done = 1'b1;
        cyc(1);
        fetch_done = 1'b0;
        cyc(2);
        cyc(63);
        total++;
        if (error !== 1'b0 || bus_grant !== 5'b00100) begin
            bad++;
            $display("FAIL etmo_early got=%b/%b exp=0/00100",
                     error, bus_grant);
        end
        cyc(1);
        total++;
        if ({error, err_code, bus_grant} !== 8'b1_10_00000) begin
            bad++;
            $display("FAIL etmo_err got=%b exp=11000000",
                     {error, err_code, bus_grant});
        end
    endtask

    task automatic test_done_at_limit();
        do_reset();
        run   = 1'b1;
        instr = 16'h1000;
        cyc(1);
        cyc(63);
        fetch_done = 1'b1;
        cyc(1);
        fetch_done = 1'b0;
        total++;
        if (error !== 1'b0 || bus_grant !== 5'b0) begin
            bad++;
            $display("FAIL flimit got=%b/%b exp=0/00000", error, bus_grant);
        end
        cyc(2);
        cyc(63);
        unit_done = 4'b0010;
        run       = 1'b0;
        cyc(1);
        unit_done = 4'b0;
        total++;
        if (error !== 1'b0 || instr_count !== 16'd1) begin
            bad++;
            $display("FAIL elimit got=%b/%0d exp=0/1", error, instr_count);
        end
    endtask

    task automatic test_rst_mid_wait();
        do_reset();
        run   = 1'b1;
        instr = 16'h0085;
        cyc(1);
        fetch_done = 1'b1;
        cyc(1);
        fetch_done = 1'b0;
        cyc(4);
        rst = 1'b1;
        run = 1'b0;
        cyc(1);
        total++;
        if ({fetch_start, unit_start, bus_grant, param1, param2} !== 22'b0) begin
            bad++;
            $display("FAIL rstw_out got=%b exp=0",
                     {fetch_start, unit_start, bus_grant, param1, param2});
        end
        rst = 1'b0;
        cyc(2);
        total++;
        if ({fetch_start, bus_grant, error, instr_count} !== 23'b0) begin
            bad++;
            $display("FAIL rstw_idle got=%b/%b/%b/%0d exp=0",
                     fetch_start, bus_grant, error, instr_count);
        end
        run = 1'b1;
        cyc(1);
        total++;
        if ({fetch_start, bus_grant} !== 6'b1_00001) begin
            bad++;
            $display("FAIL rstw_restart got=%b exp=100001",
                     {fetch_start, bus_grant});
        end
    endtask

    task automatic test_stray();
        do_reset();
        run   = 1'b1;
        instr = 16'h0085;
        cyc(1);
        fetch_done = 1'b1;
        cyc(1);
        fetch_done = 1'b0;
        cyc(2);
        unit_done  = 4'b0100;
        fetch_done = 1'b1;
        instr      = 16'h0FFF;
        cyc(1);
        unit_done  = 4'b0;
        fetch_done = 1'b0;
        total++;
        if (bus_grant !== 5'b00010 || instr_count !== 16'd0) begin
            bad++;
            $display("FAIL stray_done got=%b/%0d exp=00010/0",
                     bus_grant, instr_count);
        end
        total++;
        if ({param1, param2} !== {6'd2, 6'd5}) begin
            bad++;
            $display("FAIL stray_fetch got=%0d/%0d exp=2/5", param1, param2);
        end
        unit_done = 4'b0001;
        run       = 1'b0;
        cyc(1);
        unit_done = 4'b0;
        total++;
        if (instr_count !== 16'd1) begin
            bad++;
            $display("FAIL stray_retire got=%0d exp=1", instr_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.count_q = 16'hFFFF;
        cyc(1);
        release dut.count_q;
        cyc(1);
        total++;
        if (instr_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_preset got=%h exp=ffff", instr_count);
        end
        run   = 1'b1;
        instr = 16'h0000;
        cyc(1);
        fetch_done = 1'b1;
        cyc(1);
        fetch_done = 1'b0;
        cyc(2);
        unit_done = 4'b0001;
        run       = 1'b0;
        cyc(1);
        unit_done = 4'b0;
        total++;
        if (instr_count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap got=%h exp=0000", instr_count);
        end
    endtask

    initial begin
        rst        = 1'b1;
        run        = 1'b0;
        fetch_done = 1'b0;
        unit_done  = 4'b0;
        instr      = 16'h0;
        test_reset();
        test_movi();
        test_back_to_back();
        test_halt();
        test_illegal();
        test_fetch_timeout();
        test_exec_timeout();
        test_done_at_limit();
        test_rst_mid_wait();
        test_stray();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
